l2_input_sched: RTL and testbench

L2_INPUT_SCHED -- requirements
Module: l2_input_sched

---
 rtl/spandex_consts.sv | 14 +
 rtl/spandex_types.sv | 10 +
 rtl/l2_sched_prio_enc.sv | 30 +++
 rtl/l2_input_sched.sv | 144 ++++++++++++++
 tb/tb_l2_input_sched.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/spandex_consts.sv
// Shared constants for the L2 scheduling logic: grant bit positions and
// starvation counter width.
package spandex_consts;

    localparam int GRANT_W   = 5;
    localparam int GRANT_RSP   = 0;
    localparam int GRANT_FWD   = 1;
    localparam int GRANT_FENCE = 2;
    localparam int GRANT_FLUSH = 3;
    localparam int GRANT_CPU   = 4;

    localparam int L2_STARVE_CNT_BITS = 4;

endpackage

// File: rtl/spandex_types.sv
// Shared type definitions for the L2 scheduling logic.
package spandex_types;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2
    } l2_sched_state_t;

endpackage

// File: rtl/l2_sched_prio_enc.sv
// One-hot priority selector for the L2 input scheduler.
// Normal order: rsp > fwd > fence > flush > cpu_req.
// Starved order: rsp > cpu_req > fwd > fence > flush.
module l2_sched_prio_enc
    import spandex_consts::*;
(
    input  logic [GRANT_W-1:0] elig,
    input  logic               starve_active,
    output logic [GRANT_W-1:0] onehot
);

    // Select the single highest-priority eligible source.
    always_comb begin
        onehot = '0;
        if (elig[GRANT_RSP]) begin
            onehot[GRANT_RSP] = 1'b1;
        end else if (starve_active && elig[GRANT_CPU]) begin
            onehot[GRANT_CPU] = 1'b1;
        end else if (elig[GRANT_FWD]) begin
            onehot[GRANT_FWD] = 1'b1;
        end else if (elig[GRANT_FENCE]) begin
            onehot[GRANT_FENCE] = 1'b1;
        end else if (elig[GRANT_FLUSH]) begin
            onehot[GRANT_FLUSH] = 1'b1;
        end else if (elig[GRANT_CPU]) begin
            onehot[GRANT_CPU] = 1'b1;
        end
    end

endmodule

// File: rtl/l2_input_sched.sv
// L2 input scheduler: arbitrates five request sources into a single
// one-hot grant, holds it until the pipeline reports completion.
// Optional feature macro: L2_STARVE_GUARD_EN enables the cpu_req
// starvation counter and priority promotion; without it priority is fixed.
module l2_input_sched
    import spandex_types::*;
    import spandex_consts::*;
#(
    parameter logic [L2_STARVE_CNT_BITS-1:0] STARVE_LIMIT = 4'd15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rsp_valid,
    input  logic               fwd_valid,
    input  logic               fence_valid,
    input  logic               flush_valid,
    input  logic               cpu_req_valid,
    input  logic               set_conflict,
    input  logic               fwd_stall,
    input  logic               evict_stall,
    input  logic               ongoing_flush,
    input  logic               mshr_full,
    input  logic               mshr_empty,
    input  logic               pipe_done,
    output logic [GRANT_W-1:0] grant,
    output logic               grant_valid,
    output logic               busy,
    output logic               starve_active,
    output logic               protocol_err
);

    l2_sched_state_t    state_q;
    l2_sched_state_t    state_d;
    logic               arm_q;
    logic [GRANT_W-1:0] grant_q;
    logic [GRANT_W-1:0] elig;
    logic [GRANT_W-1:0] win;
    logic               perr_q;

    // Per-source eligibility; rsp ignores every stall so MSHRs always drain.
    always_comb begin
        elig              = '0;
        elig[GRANT_RSP]   = rsp_valid;
        elig[GRANT_FWD]   = fwd_valid & ~fwd_stall & ~evict_stall;
        elig[GRANT_FENCE] = fence_valid & ~evict_stall & mshr_empty;
        elig[GRANT_FLUSH] = flush_valid & ~evict_stall & mshr_empty;
        elig[GRANT_CPU]   = cpu_req_valid & ~set_conflict & ~evict_stall
                            & ~mshr_full & ~ongoing_flush;
    end

    l2_sched_prio_enc u_prio_enc (
        .elig          (elig),
        .starve_active (starve_active),
        .onehot        (win)
    );

    // State register; arm_q blocks arbitration on the first edge after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            arm_q   <= 1'b1;
        end
    end

    // Next-state logic: arbitrate only from IDLE, leave on pipe_done.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (arm_q && (|win)) state_d = GRANT;
            GRANT:   state_d = pipe_done ? IDLE : BUSY;
            BUSY:    if (pipe_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant register: capture winner on IDLE->GRANT, clear on return to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_q <= '0;
        end else if (state_q == IDLE) begin
            grant_q <= arm_q ? win : '0;
        end else if (state_d == IDLE) begin
            grant_q <= '0;
        end
    end

    // Sticky error: completion reported while nothing is granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perr_q <= 1'b0;
        end else if (state_q == IDLE && pipe_done) begin
            perr_q <= 1'b1;
        end
    end

    // Output decode from the current state.
    always_comb begin
        grant_valid = 1'b0;
        busy        = 1'b0;
        if (state_q == GRANT) grant_valid = 1'b1;
        if (state_q != IDLE)  busy        = 1'b1;
    end

    assign grant        = grant_q;
    assign protocol_err = perr_q;

`ifdef L2_STARVE_GUARD_EN
    logic [L2_STARVE_CNT_BITS-1:0] starve_cnt_q;
    logic                          take;

    function automatic logic [L2_STARVE_CNT_BITS-1:0] sat_inc(
        input logic [L2_STARVE_CNT_BITS-1:0] v,
        input logic [L2_STARVE_CNT_BITS-1:0] lim
    );
        return (v < lim) ? v + 1'b1 : lim;
    endfunction

    assign take = (state_q == IDLE) && (state_d == GRANT);

    // Count arbitration rounds cpu_req loses while eligible; clear on win or idle drop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_q <= '0;
        end else if (take && win[GRANT_CPU]) begin
            starve_cnt_q <= '0;
        end else if (state_q == IDLE && !cpu_req_valid) begin
            starve_cnt_q <= '0;
        end else if (take && elig[GRANT_CPU]) begin
            starve_cnt_q <= sat_inc(starve_cnt_q, STARVE_LIMIT);
        end
    end

    assign starve_active = (starve_cnt_q == STARVE_LIMIT);
`else
    logic unused_starve_limit;

    assign unused_starve_limit = ^STARVE_LIMIT;
    assign starve_active       = 1'b0;
`endif

endmodule

// File: tb/tb_l2_input_sched.sv
// Self-checking bench for l2_input_sched: table of single-arbitration
// vectors plus hand sequences for reset, blocking, hold, and starvation.
module tb_l2_input_sched;

`ifdef L2_STARVE_GUARD_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rsp_valid, fwd_valid, fence_valid, flush_valid, cpu_req_valid;
    logic       set_conflict, fwd_stall, evict_stall, ongoing_flush, mshr_full, mshr_empty;
    logic       pipe_done;
    logic [4:0] grant;
    logic       grant_valid, busy, starve_active, protocol_err;

    int n_cmp = 0;
    int n_err = 0;
    logic [4:0] exp_q[$];

    // v = {cpu, flush, fence, fwd, rsp}
    // st = {set_conflict, fwd_stall, evict_stall, ongoing_flush, mshr_full, mshr_empty}
    typedef struct packed {
        logic [4:0] v;
        logic [5:0] st;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[14];

    l2_input_sched #(.STARVE_LIMIT(4'd15)) dut (
        .clk           (clk),
        .rst           (rst),
        .rsp_valid     (rsp_valid),
        .fwd_valid     (fwd_valid),
        .fence_valid   (fence_valid),
        .flush_valid   (flush_valid),
        .cpu_req_valid (cpu_req_valid),
        .set_conflict  (set_conflict),
        .fwd_stall     (fwd_stall),
        .evict_stall   (evict_stall),
        .ongoing_flush (ongoing_flush),
        .mshr_full     (mshr_full),
        .mshr_empty    (mshr_empty),
        .pipe_done     (pipe_done),
        .grant         (grant),
        .grant_valid   (grant_valid),
        .busy          (busy),
        .starve_active (starve_active),
        .protocol_err  (protocol_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_in(input logic [4:0] v, input logic [5:0] st);
        {cpu_req_valid, flush_valid, fence_valid, fwd_valid, rsp_valid} = v;
        {set_conflict, fwd_stall, evict_stall, ongoing_flush, mshr_full, mshr_empty} = st;
    endtask

    // Scoreboard: every grant pulse must match the oldest expected grant.
    always @(negedge clk) begin
        if (grant_valid) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_grant", {27'd0, grant}, 32'd0);
            end else begin
                check("sb_grant", {27'd0, grant}, {27'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{5'b11111, 6'b000001, 5'b00001};
        vecs[1]  = '{5'b11110, 6'b000001, 5'b00010};
        vecs[2]  = '{5'b11110, 6'b010001, 5'b00100};
        vecs[3]  = '{5'b11100, 6'b000000, 5'b10000};
        vecs[4]  = '{5'b11000, 6'b000001, 5'b01000};
        vecs[5]  = '{5'b11111, 6'b001001, 5'b00001};
        vecs[6]  = '{5'b11110, 6'b001001, 5'b00000};
        vecs[7]  = '{5'b10000, 6'b100001, 5'b00000};
        vecs[8]  = '{5'b10000, 6'b000011, 5'b00000};
        vecs[9]  = '{5'b10000, 6'b000101, 5'b00000};
        vecs[10] = '{5'b10000, 6'b000001, 5'b10000};
        vecs[11] = '{5'b00001, 6'b111110, 5'b00001};
        vecs[12] = '{5'b01100, 6'b000000, 5'b00000};
        vecs[13] = '{5'b00000, 6'b000001, 5'b00000};

        // Reset with a request pending; outputs must be idle.
        rst = 1'b0;
        pipe_done = 1'b0;
        apply_in(5'b00001, 6'b000001);
        tick(); tick();
        check("rst_grant", {27'd0, grant}, 32'd0);
        check("rst_gv", {31'd0, grant_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_starve", {31'd0, starve_active}, 32'd0);
        check("rst_perr", {31'd0, protocol_err}, 32'd0);

        // Release: no grant at the first edge, grant at the second.
        rst = 1'b1;
        exp_q.push_back(5'b00001);
        tick();
        check("post_rst_edge1_gv", {31'd0, grant_valid}, 32'd0);
        tick();
        check("post_rst_edge2_gv", {31'd0, grant_valid}, 32'd1);
        check("post_rst_edge2_grant", {27'd0, grant}, 32'd1);
        apply_in(5'b00000, 6'b000001);
        pipe_done = 1'b1;
        tick();
        pipe_done = 1'b0;
        check("post_rst_done_busy", {31'd0, busy}, 32'd0);
        tick();

        // Table of single arbitrations from IDLE.
        for (int i = 0; i < 14; i++) begin
            apply_in(vecs[i].v, vecs[i].st);
            if (vecs[i].exp != 5'b0) exp_q.push_back(vecs[i].exp);
            tick();
            check($sformatf("vec%0d_grant", i), {27'd0, grant}, {27'd0, vecs[i].exp});
            check($sformatf("vec%0d_gv", i), {31'd0, grant_valid}, {31'd0, |vecs[i].exp});
            check($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, |vecs[i].exp});
            apply_in(5'b00000, 6'b000001);
            if (vecs[i].exp != 5'b0) begin
                pipe_done = 1'b1;
                tick();
                pipe_done = 1'b0;
                check($sformatf("vec%0d_idle", i), {31'd0, busy}, 32'd0);
            end
            tick();
        end

        // cpu_req blocked by each blocker in turn, then released.
        apply_in(5'b10000, 6'b100001);
        tick(); tick();
        check("blk_conflict_busy", {31'd0, busy}, 32'd0);
        apply_in(5'b10000, 6'b000011);
        tick(); tick();
        check("blk_mshr_full_busy", {31'd0, busy}, 32'd0);
        apply_in(5'b10000, 6'b000101);
        tick(); tick();
        check("blk_flush_busy", {31'd0, busy}, 32'd0);
        exp_q.push_back(5'b10000);
        apply_in(5'b10000, 6'b000001);
        tick();
        check("blk_release_grant", {27'd0, grant}, 32'h10);
        apply_in(5'b00000, 6'b000001);
        pipe_done = 1'b1;
        tick();
        pipe_done = 1'b0;
        tick();

        // Grant fwd, then scramble inputs while BUSY; grant must hold.
        exp_q.push_back(5'b00010);
        apply_in(5'b00010, 6'b000001);
        tick();
        for (int k = 0; k < 4; k++) begin
            apply_in(5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)));
            tick();
            check($sformatf("hold%0d_grant", k), {27'd0, grant}, 32'h02);
            check($sformatf("hold%0d_busy", k), {31'd0, busy}, 32'd1);
        end
        apply_in(5'b00000, 6'b000001);
        pipe_done = 1'b1;
        tick();
        check("hold_done_grant", {27'd0, grant}, 32'd0);
        check("perr_before", {31'd0, protocol_err}, 32'd0);
        tick();
        pipe_done = 1'b0;
        check("perr_set", {31'd0, protocol_err}, 32'd1);
        tick(); tick();
        check("perr_sticky", {31'd0, protocol_err}, 32'd1);
        check("perr_idle", {31'd0, busy}, 32'd0);

        // Reset while BUSY: outputs clear immediately.
        exp_q.push_back(5'b00001);
        apply_in(5'b00001, 6'b000001);
        tick(); tick();
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_grant", {27'd0, grant}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_gv", {31'd0, grant_valid}, 32'd0);
        check("mid_rst_perr", {31'd0, protocol_err}, 32'd0);
        check("mid_rst_starve", {31'd0, starve_active}, 32'd0);
        tick();
        rst = 1'b1;
        exp_q.push_back(5'b00001);
        tick();
        tick();
        check("resume_grant", {27'd0, grant}, 32'd1);
        apply_in(5'b00000, 6'b000001);
        pipe_done = 1'b1;
        tick();
        pipe_done = 1'b0;
        tick();

        // fwd and cpu_req continuously requesting: starvation behaviour.
        apply_in(5'b10010, 6'b000001);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("starve%0d_active", i), {31'd0, starve_active},
                  {31'd0, STARVE_ON && (i == 15)});
            exp_q.push_back((STARVE_ON && i == 15) ? 5'b10000 : 5'b00010);
            tick();
            tick();
            pipe_done = 1'b1;
            tick();
            pipe_done = 1'b0;
        end
        check("starve_cleared", {31'd0, starve_active}, 32'd0);
        apply_in(5'b00000, 6'b000001);
        tick(); tick();

        check("sb_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
